// File: rtl/result_uart_streamer.sv
// Frames buffered INT32 results into a UART byte stream: A5, LEN_LO, LEN_HI, little-endian words.
// Define RESULT_STREAM_CHKSUM_EN to append a mod-256 checksum byte (LEN + payload, SYNC excluded).
module result_uart_streamer #(
   parameter int          ADDR_W     = 10,
   parameter int          DATA_WIDTH = 32,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     cfg_base_addr,
   input  logic [15:0]           cfg_num_words,
   output logic                  buf_rd_en,
   output logic [ADDR_W-1:0]     buf_rd_addr,
   input  logic [DATA_WIDTH-1:0] buf_rd_data,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           bytes_sent
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_RD,
      S_WAIT,
      S_SEND,
`ifdef RESULT_STREAM_CHKSUM_EN
      S_CHK,
`endif
      S_FIN
   } state_t;

`ifdef RESULT_STREAM_CHKSUM_EN
   localparam state_t END_ST = S_CHK;
`else
   localparam state_t END_ST = S_FIN;
`endif

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [15:0]             num_q, num_d;
   logic [15:0]             word_idx_q, word_idx_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic [31:0]             bytes_q, bytes_d;
`ifdef RESULT_STREAM_CHKSUM_EN
   logic [7:0]              chk_q, chk_d;
`endif
   logic                    hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         num_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         bytes_q    <= '0;
`ifdef RESULT_STREAM_CHKSUM_EN
         chk_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         shreg_q    <= shreg_d;
         bytes_q    <= bytes_d;
`ifdef RESULT_STREAM_CHKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

   // All outputs decode registered state only, so tx_valid never sees tx_ready combinationally.
   always_comb begin
      tx_valid    = (state_q == S_HDR) || (state_q == S_SEND)
`ifdef RESULT_STREAM_CHKSUM_EN
                    || (state_q == S_CHK)
`endif
                    ;
      buf_rd_en   = (state_q == S_RD);
      buf_rd_addr = (state_q == S_RD) ? base_q + ADDR_W'(word_idx_q) : '0;
      busy        = (state_q != S_IDLE) && (state_q != S_FIN);
      done        = (state_q == S_FIN);
      bytes_sent  = bytes_q;
      tx_data     = '0;
      case (state_q)
         S_HDR: begin
            case (byte_idx_q)
               2'd0:    tx_data = SYNC_BYTE;
               2'd1:    tx_data = num_q[7:0];
               default: tx_data = num_q[15:8];
            endcase
         end
         S_SEND:  tx_data = shreg_q[7:0];
`ifdef RESULT_STREAM_CHKSUM_EN
         S_CHK:   tx_data = chk_q;
`endif
         default: tx_data = '0;
      endcase
   end

   assign hs = tx_valid && tx_ready;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
      bytes_d    = hs ? bytes_q + 32'd1 : bytes_q;
`ifdef RESULT_STREAM_CHKSUM_EN
      chk_d      = chk_q;
      if (hs && !(state_q == S_HDR && byte_idx_q == 2'd0) && state_q != S_CHK)
         chk_d = chk_q + tx_data;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_HDR;
               base_d     = cfg_base_addr;
               num_d      = cfg_num_words;
               word_idx_d = '0;
               byte_idx_d = '0;
               bytes_d    = '0;
`ifdef RESULT_STREAM_CHKSUM_EN
               chk_d      = '0;
`endif
            end
         end
         S_HDR: begin
            if (hs) begin
               if (byte_idx_q == 2'd2) begin
                  byte_idx_d = '0;
                  state_d    = (num_q != 16'd0) ? S_RD : END_ST;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         S_RD:   state_d = S_WAIT;
         S_WAIT: begin
            shreg_d    = buf_rd_data;
            byte_idx_d = '0;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (hs) begin
               shreg_d = shreg_q >> 8;
               if (byte_idx_q == 2'd3) begin
                  byte_idx_d = '0;
                  word_idx_d = word_idx_q + 16'd1;
                  state_d    = (word_idx_q + 16'd1 == num_q) ? END_ST : S_RD;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
`ifdef RESULT_STREAM_CHKSUM_EN
         S_CHK: if (hs) state_d = S_FIN;
`endif
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_uart_streamer.sv
// Scoreboard bench for result_uart_streamer: expected bytes/addresses are queued at stimulus time
// and popped by independent monitors on each byte handshake and buffer read.
module tb_result_uart_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  cfg_base_addr = '0;
   logic [15:0] cfg_num_words = '0;
   logic        buf_rd_en;
   logic [9:0]  buf_rd_addr;
   logic [31:0] buf_rd_data = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        done;
   logic [31:0] bytes_sent;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned done_count = 0;
   int unsigned rd_count = 0;
   int unsigned ready_mode = 0;
   int unsigned ready_cnt = 0;
   logic [7:0]  exp_bytes[$];
   logic [9:0]  exp_addrs[$];
   logic [31:0] mem [0:1023];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

`ifdef RESULT_STREAM_CHKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   result_uart_streamer #(.ADDR_W(10), .DATA_WIDTH(32), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .bytes_sent(bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // tx_ready pattern: mode 0 always ready, mode 1 ready one cycle in three
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready_cnt++;
         tx_ready = (ready_mode == 0) ? 1'b1 : ((ready_cnt % 3) == 0);
      end
   end

   // byte scoreboard, stall stability, read-address scoreboard, done counter
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (tx_valid && tx_ready) begin
            if (exp_bytes.size() == 0) check("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_bytes.pop_front()});
         end
         if (prev_stall) begin
            check("stall_valid_held", {31'h0, tx_valid}, 32'd1);
            check("stall_data_stable", {24'h0, tx_data}, {24'h0, prev_data});
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (buf_rd_en) begin
            rd_count++;
            if (exp_addrs.size() == 0) check("unexpected_rd", {22'h0, buf_rd_addr}, 32'hFFFF_FFFF);
            else check("rd_addr", {22'h0, buf_rd_addr}, {22'h0, exp_addrs.pop_front()});
         end
         if (done) done_count++;
      end
   end

   task automatic push_frame(input logic [9:0] base, input logic [15:0] n);
      logic [7:0]  sum;
      logic [31:0] w;
      logic [9:0]  a;
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(n[7:0]);
      exp_bytes.push_back(n[15:8]);
      sum = n[7:0] + n[15:8];
      for (int i = 0; i < int'(n); i++) begin
         a = base + 10'(i);
         exp_addrs.push_back(a);
         w = mem[a];
         for (int b = 0; b < 4; b++) begin
            exp_bytes.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
         end
      end
      if (CHK_EXTRA != 0) exp_bytes.push_back(sum);
   endtask

   task automatic pulse_start(input logic [9:0] base, input logic [15:0] n, input int cycles,
                              input bit check_latency);
      @(posedge clk);
      #1;
      cfg_base_addr = base;
      cfg_num_words = n;
      start = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      start = 1'b0;
      if (check_latency) begin
         @(negedge clk);
         check("first_valid", {31'h0, tx_valid}, 32'd1);
         check("first_sync", {24'h0, tx_data}, 32'h0000_00A5);
         check("busy_in_frame", {31'h0, busy}, 32'd1);
      end
   endtask

   task automatic finish_frame(input string name, input int n);
      int unsigned k;
      k = 0;
      while (done_count == 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (done_count == 0) check({name, "_timeout"}, 32'd0, 32'd1);
      repeat (4) @(negedge clk);
      check({name, "_done_once"}, done_count, 32'd1);
      check({name, "_busy_low"}, {31'h0, busy}, 32'd0);
      check({name, "_bytes_sent"}, bytes_sent, 32'(3 + 4*n + CHK_EXTRA));
      check({name, "_rd_count"}, rd_count, 32'(n));
      check({name, "_bytes_left"}, exp_bytes.size(), 32'd0);
      check({name, "_addrs_left"}, exp_addrs.size(), 32'd0);
   endtask

   task automatic wait_bytes(input int unsigned target);
      int unsigned k;
      k = 0;
      while (bytes_sent < target && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (bytes_sent < target) check("wait_bytes_timeout", bytes_sent, target);
   endtask

   task automatic clear_counts();
      done_count = 0;
      rd_count   = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
      mem[0]     = 32'h1122_3344;
      mem[5]     = 32'hA1B2_C3D4;
      mem[6]     = 32'h0102_0304;
      mem[10'h3FE] = 32'hCAFE_BABE;
      mem[10'h3FF] = 32'h8765_4321;
      mem[10'h000] = 32'h1122_3344;
      mem[10'h001] = 32'hFFEE_DDCC;

      repeat (3) @(negedge clk);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'h0, tx_data}, 32'd0);
      check("rst_rd_en", {31'h0, buf_rd_en}, 32'd0);
      check("rst_rd_addr", {22'h0, buf_rd_addr}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_bytes", bytes_sent, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single word: A5 01 00 44 33 22 11 (+AB)
      clear_counts();
      exp_bytes = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      exp_addrs.push_back(10'h000);
      if (CHK_EXTRA != 0) exp_bytes.push_back(8'hAB);
      pulse_start(10'h000, 16'd1, 1, 1'b1);
      finish_frame("single", 1);

      // backpressure
      clear_counts();
      ready_mode = 1;
      push_frame(10'd5, 16'd2);
      pulse_start(10'd5, 16'd2, 1, 1'b0);
      finish_frame("backpressure", 2);
      ready_mode = 0;

      // zero length, start held two cycles
      clear_counts();
      push_frame(10'd0, 16'd0);
      pulse_start(10'd0, 16'd0, 2, 1'b0);
      finish_frame("zero_len", 0);

      // address wrap: 3FE,3FF,000,001
      clear_counts();
      push_frame(10'h3FE, 16'd4);
      pulse_start(10'h3FE, 16'd4, 1, 1'b0);
      finish_frame("wrap", 4);

      // start while busy is ignored
      clear_counts();
      push_frame(10'd5, 16'd2);
      pulse_start(10'd5, 16'd2, 1, 1'b0);
      wait_bytes(5);
      pulse_start(10'd100, 16'd7, 1, 1'b0);
      finish_frame("busy_start", 2);

      // mid-frame asynchronous reset
      clear_counts();
      push_frame(10'd0, 16'd3);
      pulse_start(10'd0, 16'd3, 1, 1'b0);
      wait_bytes(4);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", {31'h0, tx_valid}, 32'd0);
      check("midrst_busy", {31'h0, busy}, 32'd0);
      check("midrst_bytes", bytes_sent, 32'd0);
      exp_bytes.delete();
      exp_addrs.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_counts();
      push_frame(10'd0, 16'd1);
      pulse_start(10'd0, 16'd1, 1, 1'b1);
      finish_frame("after_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_uart_streamer.md
Name: result_uart_streamer

Overview:
Drains INT32 results from the output result buffer and serializes them into a framed 8-bit byte stream for the UART transmitter. It is the egress counterpart of the 8→32 metadata assembly path: it splits 32-bit words into bytes and prefixes a sync/length header. It sits between the output BRAM read port and uart_tx's data_in/data_valid/data_ready handshake.

Parameters:
ADDR_W, 10, output buffer address width (1024 words)
DATA_WIDTH, 32, result word width; fixed at 32 (4 bytes per word)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begin one frame (accepted only in IDLE)
cfg_base_addr  input  ADDR_W  first buffer word address; sampled on accepted start
cfg_num_words  input  16  words to send, 0..65535; sampled on accepted start
buf_rd_en  output  1  buffer read strobe
buf_rd_addr  output  ADDR_W  buffer read address
buf_rd_data  input  32  buffer read data; valid exactly 1 cycle after buf_rd_en
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX can accept a byte
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last byte handshake
bytes_sent  output  32  running count of handshaked bytes; cleared on accepted start

Behaviour:
- Reset: tx_valid=0, tx_data=0, buf_rd_en=0, buf_rd_addr=0, busy=0, done=0, bytes_sent=0, state=IDLE.
- Byte handshake: a transfer occurs when tx_valid && tx_ready on a rising edge. While tx_valid=1 and tx_ready=0, tx_data must not change. tx_valid must not depend combinationally on tx_ready.
- Frame order: SYNC_BYTE, LEN_LO, LEN_HI (cfg_num_words), then each word little-endian (bits 7:0 first), then an optional checksum byte.
- FSM states: IDLE, HDR, RD, WAIT, SEND, CHK, FIN.
  - IDLE --start--> HDR. Next cycle: tx_valid=1, tx_data=SYNC_BYTE, busy=1. Latency from start to first tx_valid is 1 cycle.
  - HDR emits 3 bytes with a byte index 0..2. After the LEN_HI handshake it goes to RD if num_words>0, else to CHK (when enabled) or FIN.
  - RD: buf_rd_en=1 for exactly one cycle, buf_rd_addr = (base + word_idx) mod 2^ADDR_W (wraps silently); tx_valid=0.
  - WAIT: capture buf_rd_data into a 32-bit shift register.
  - SEND: present 4 bytes in turn. After the 4th handshake, word_idx increments; go to RD if words remain, else CHK/FIN.
  - CHK emits the checksum byte (feature on only), then goes to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Throughput: a 2-cycle bubble (RD, WAIT) between words is allowed and required. There are no bubbles within a word or within the header.
- start while busy is ignored, and the frame in progress is unaffected.
- Holding start in IDLE for consecutive cycles starts only one frame. A new frame can start only on a start pulse seen in IDLE after FIN.
- bytes_sent increments by 1 per handshake and is 32-bit wrapping. Final value = 3 + 4*N (+1 with checksum).
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). No partial-frame recovery is attempted.
- buf_rd_en is never asserted outside the RD state.

Optional Feature:
RESULT_STREAM_CHKSUM_EN
- Defined: after the last payload byte (or after LEN_HI when N=0), one extra byte is sent. Value = 8-bit modulo-256 sum of LEN_LO, LEN_HI and all payload bytes; SYNC_BYTE is excluded. The accumulator clears on accepted start.
- Undefined: the CHK state and accumulator are absent. Transitions go directly to FIN and the frame ends with the last payload byte.

Test Plan:
- Single word: base=0, N=1, buf[0]=32'h11223344, tx_ready=1 always -> bytes A5,01,00,44,33,22,11 (+checksum 8'hAB if enabled). done pulses once; bytes_sent=7 (8 with checksum).
- Backpressure: N=2, tx_ready toggling 1-of-3 cycles -> identical byte sequence to the no-stall case; tx_data stable on every stalled cycle; no byte lost or duplicated.
- Zero length: N=0 -> bytes A5,00,00 (+00); buf_rd_en never asserted; done pulses; busy drops.
- Address wrap: base=10'h3FE, N=4 -> buf_rd_addr sequence 3FE,3FF,000,001; 19 bytes total without checksum.
- start while busy: second start pulse mid-payload -> ignored; exactly one frame emitted; bytes_sent not cleared.
- Mid-frame reset: rst_n low during SEND -> tx_valid=0 and busy=0 in the same cycle. A new start after release emits a fresh frame beginning with A5.
